// File: rtl/vga_fb_reader.sv
// vga_fb_reader: scan-out engine for the 8-bit frame buffer.
// Generates VGA timing from a pixel-clock enable, issues one frame-buffer read
// per visible pixel, and returns the read data as a pixel stream aligned with
// the syncs.
//
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   pix_ce       pixel tick enable; all timing advances only when high
//   fb_ready     frame buffer contents valid (sampled on pixel ticks)
//   re           frame-buffer read enable (combinational)
//   read_addr    linear row-major read address
//   fb_data      frame-buffer read data, valid one clk after re
//   hsync/vsync  active-low syncs
//   video_on     output pixel is visible
//   pixel        output pixel value, 0 outside the visible area
//   frame_start  one-clk pulse with output pixel (0,0)
module vga_fb_reader #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned ADDR_W   = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pix_ce,
   input  logic              fb_ready,
   output logic              re,
   output logic [ADDR_W-1:0] read_addr,
   input  logic [7:0]        fb_data,
   output logic              hsync,
   output logic              vsync,
   output logic              video_on,
   output logic [7:0]        pixel,
   output logic              frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned H_W     = $clog2(H_TOTAL);
   localparam int unsigned V_W     = $clog2(V_TOTAL);

   localparam logic [H_W-1:0]    H_ACT     = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0]    H_LAST    = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0]    HS_BEG    = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0]    HS_END    = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [V_W-1:0]    V_ACT     = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0]    V_LAST    = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0]    VS_BEG    = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0]    VS_END    = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [H_W-1:0]    h_cnt;
   logic [V_W-1:0]    v_cnt;
   logic [ADDR_W-1:0] addr_cnt;

   // stage-1 pipeline registers
   logic s1_active;
   logic s1_hs;
   logic s1_vs;
   logic s1_first;

   logic active_c;
   logic hs_c;
   logic vs_c;
   logic first_c;
   logic h_wrap_c;
   logic frame_end_c;

   // position decodes from the current counters
   assign active_c    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_c        = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
   assign vs_c        = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
   assign first_c     = (h_cnt == '0) && (v_cnt == '0);
   assign h_wrap_c    = (h_cnt == H_LAST);
   assign frame_end_c = h_wrap_c && (v_cnt == V_LAST);

   // Reads only on ticks, so the RAM output holds between ticks.
   assign re        = (state_q == RUN) && active_c && pix_ce;
   assign read_addr = addr_cnt;

   // next-state logic; a mid-frame fb_ready drop waits for the frame end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pix_ce && fb_ready) state_d = RUN;
         RUN:     if (pix_ce && frame_end_c && !fb_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state, counters and two-stage output pipeline
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         h_cnt       <= '0;
         v_cnt       <= '0;
         addr_cnt    <= '0;
         s1_active   <= 1'b0;
         s1_hs       <= 1'b0;
         s1_vs       <= 1'b0;
         s1_first    <= 1'b0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         video_on    <= 1'b0;
         pixel       <= 8'h00;
         frame_start <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_start <= 1'b0;
         if (pix_ce) begin
            if (state_q == RUN) begin
               h_cnt <= h_wrap_c ? '0 : h_cnt + H_W'(1);
               if (h_wrap_c) begin
                  v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
               end
               // Holds at the last visible address through vertical blanking.
               if (frame_end_c) begin
                  addr_cnt <= '0;
               end else if (active_c && (addr_cnt != ADDR_LAST)) begin
                  addr_cnt <= addr_cnt + ADDR_W'(1);
               end
               s1_active <= active_c;
               s1_hs     <= hs_c;
               s1_vs     <= vs_c;
               s1_first  <= first_c;
            end else begin
               h_cnt     <= '0;
               v_cnt     <= '0;
               addr_cnt  <= '0;
               s1_active <= 1'b0;
               s1_hs     <= 1'b0;
               s1_vs     <= 1'b0;
               s1_first  <= 1'b0;
            end
            // fb_data was captured by the RAM on the previous tick's read.
            video_on    <= s1_active;
            pixel       <= s1_active ? fb_data : 8'h00;
            hsync       <= ~s1_hs;
            vsync       <= ~s1_vs;
            frame_start <= s1_first;
         end
      end
   end

endmodule

// File: doc/vga_fb_reader.md
# vga_fb_reader

Scan-out engine for the 640x480 8-bit frame buffer. It generates standard 640x480@60 VGA timing from a pixel-clock enable and drives the frame buffer's read port (`re`, `read_addr`) one address per active pixel. It returns the registered read data as a pixel stream, aligned with `hsync`, `vsync` and `video_on`. It sits between the dual-port frame buffer's read side and the VGA output pins; the drawing logic owns the write side.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in ticks
- `H_SYNC`, 96: horizontal sync width, in ticks
- `H_BP`, 48: horizontal back porch, in ticks
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `ADDR_W`, 20: frame-buffer address width

Ports:
- `clk` in 1: single system clock
- `rst_n` in 1: reset, synchronous, active-low
- `pix_ce` in 1: pixel tick enable; all timing advances only on cycles where it is 1
- `fb_ready` in 1: frame buffer contents valid; driven from the buffer's `initialized`
- `re` out 1: read enable to the frame buffer
- `read_addr` out ADDR_W: linear read address, row-major (y*640+x)
- `fb_data` in 8: frame-buffer `data_out`; registered, valid one `clk` after the `re` edge
- `hsync` out 1: horizontal sync, active-low
- `vsync` out 1: vertical sync, active-low
- `video_on` out 1: output pixel is in the visible area
- `pixel` out 8: pixel value; 0 whenever `video_on` = 0
- `frame_start` out 1: one-`clk` pulse marking output pixel (0,0)

## Operation
- Counters:
  - `h_cnt` counts 0..799 and `v_cnt` counts 0..524.
  - Both advance only on `pix_ce`. `h_cnt` wraps at 799; `v_cnt` increments on that wrap and itself wraps at 524.
- Decodes, all from the current counters:
  - active = `h_cnt`<640 && `v_cnt`<480
  - hs = `h_cnt` in [656,751]
  - vs = `v_cnt` in [490,491]
- Address counter:
  - `addr_cnt` (ADDR_W bits) increments on every `pix_ce` tick where active is true.
  - It clears to 0 on the tick where (`h_cnt`,`v_cnt`) = (799,524), and in IDLE.
  - `read_addr` = `addr_cnt`. It never exceeds 307199. No multiplier.
- `re` = RUN && active && `pix_ce`, combinational. The RAM output therefore changes only on pixel ticks and holds between them.
- State machine, evaluated on `pix_ce`:
  - IDLE: counters and `addr_cnt` held at 0; pipeline loads blank values (syncs 1, `video_on` 0). Goes to RUN when `fb_ready` = 1; the first RUN tick is at (0,0).
  - RUN: counters run. Goes to IDLE only on the (799,524) tick with `fb_ready` = 0. A drop of `fb_ready` mid-frame is ignored until the frame ends, so frames never tear.
- Output pipeline, two stages, both clocked on `pix_ce`:
  - Stage 1 registers active, hs, vs, and first = (`h_cnt`,`v_cnt`)==(0,0).
  - Stage 2 registers the outputs: `pixel` = stage-1 active ? `fb_data` : 0, plus `video_on`, `hsync` = ~hs, `vsync` = ~vs.
  - `frame_start` is set when stage-1 first is loaded into stage 2, and is cleared on the next `clk`.
- Reset values: `hsync` = 1, `vsync` = 1, `video_on` = 0, `pixel` = 0, `frame_start` = 0, `re` = 0, `read_addr` = 0, state IDLE, all counters 0.

## Timing
- All outputs lag the counter position that produced them by exactly 2 `pix_ce` ticks, and are mutually aligned.
- With `pix_ce` = 1 constantly:
  - line = 800 `clk`, frame = 420000 `clk`
  - `hsync` low for 96 `clk`, `vsync` low for 1600 `clk`
- With `pix_ce` at 1/N duty, every period scales by N. `fb_data` must be valid one `clk` after `re`, which holds for any `pix_ce` pattern.
- `rst_n` = 0 sampled on any edge forces all reset values on that edge, regardless of `pix_ce`. A reset mid-frame abandons the frame; scanning restarts from (0,0) only after `fb_ready` is seen again.
- `fb_ready` is sampled only on `pix_ce` ticks.
- Boundary conditions:
  - Address wrap at end of frame and the RUN->IDLE transition happen on the same tick.
  - IDLE->RUN immediately after RUN->IDLE is legal: if `fb_ready` returns on the next tick, the next frame starts at address 0.

## Test plan
- Reset, then `fb_ready` = 1, `pix_ce` = 1, RAM model holding data = addr[7:0]:
  - `read_addr` runs 0..639, holds during blanking, row 1 starts at 640, last address 307199.
  - `pixel` equals addr[7:0] exactly 2 ticks after each read.
- Sync measurement:
  - `hsync` low 96 ticks, starting 656 ticks after the line start, with a period of 800.
  - `vsync` low 1600 ticks, with a period of 420000.
  - `video_on` high 640 of every 800 ticks on lines 0..479.
- `pix_ce` toggling every other `clk`:
  - all periods double in `clk`
  - `re` is never high when `pix_ce` = 0
  - pixel data is unchanged from the scenario above
- `fb_ready` dropped at line 100:
  - the frame completes to (799,524), then IDLE: `re` = 0, syncs = 1, `video_on` = 0
  - re-raising `fb_ready` restarts at `read_addr` 0 with `frame_start` pulsing
- `rst_n` pulsed low at pixel (300,200) -> on the next edge, all outputs take their reset values, and `read_addr` = 0.
- `frame_start` pulses exactly once per 420000 ticks, for exactly one `clk`, in the same cycle `video_on` first rises in the frame.
